// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use/branch stalls, long-op scoreboard, dmem wait FSM.
// Optional stall-cycle performance counter (StallCnt) enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned MEM_TO   = 255
`ifdef HAZARD_PERF_EN
  , parameter int unsigned PERF_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              LongIssueE,
  input  logic              LongDoneValid,
  input  logic [REG_AW-1:0] LongDoneReg,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushE,
  output logic              FlushW,
  output logic              SbFull,
  output logic              MemErr
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0] StallCnt
`endif
);

  localparam int unsigned NREG = 2**REG_AW;
  localparam int unsigned PCW  = $clog2(MAX_PEND + 1);
  localparam int unsigned TOW  = $clog2(MEM_TO + 1);

  typedef enum logic {RUN, MWAIT} mstate_t;

  mstate_t         state, state_n;
  logic [NREG-1:0] pend, pend_n;
  logic [PCW-1:0]  pcnt;
  logic [TOW-1:0]  tocnt, tocnt_n;
  logic            memerr_q;
  logic            memstall, issstall, lwstall, brstall, sbstall;
  logic            lset, lclr;

  always_comb begin
    lwstall  = MemtoRegE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
    brstall  = BranchD &&
               ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == rsD) || (WriteRegE == rtD))) ||
                (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == rsD) || (WriteRegM == rtD))));
    sbstall  = ((rsD != '0) && pend[rsD]) || ((rtD != '0) && pend[rtD]);
    SbFull   = (pcnt == PCW'(MAX_PEND));
    issstall = LongIssueE && (SbFull || ((WriteRegE != '0) && pend[WriteRegE]));
  end

  // Data-memory wait FSM; the RUN cycle that sees a miss already stalls.
  always_comb begin
    state_n  = state;
    tocnt_n  = '0;
    memstall = 1'b0;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          memstall = 1'b1;
          state_n  = MWAIT;
        end
      end
      MWAIT: begin
        if (MemReadyM) begin
          state_n = RUN;
        end else begin
          memstall = 1'b1;
          tocnt_n  = (tocnt == TOW'(MEM_TO)) ? tocnt : tocnt + 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      tocnt    <= '0;
      memerr_q <= 1'b0;
    end else begin
      state    <= state_n;
      tocnt    <= tocnt_n;
      memerr_q <= memerr_q || ((state_n == MWAIT) && (tocnt_n == TOW'(MEM_TO)));
    end
  end

  assign MemErr = memerr_q;

  // Set and clear can never hit the same reg: a pending dest raises issstall.
  always_comb begin
    lset   = LongIssueE && !memstall && !issstall && (WriteRegE != '0);
    lclr   = LongDoneValid && pend[LongDoneReg];
    pend_n = pend;
    if (lclr) pend_n[LongDoneReg] = 1'b0;
    if (lset) pend_n[WriteRegE] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      pcnt <= '0;
    end else begin
      pend <= pend_n;
      if (lset && !lclr)      pcnt <= pcnt + 1'b1;
      else if (lclr && !lset) pcnt <= pcnt - 1'b1;
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      if ((rsE != '0) && RegWriteM && (WriteRegM == rsE))      ForwardAE = 2'b10;
      else if ((rsE != '0) && RegWriteW && (WriteRegW == rsE)) ForwardAE = 2'b01;
      if ((rtE != '0) && RegWriteM && (WriteRegM == rtE))      ForwardBE = 2'b10;
      else if ((rtE != '0) && RegWriteW && (WriteRegW == rtE)) ForwardBE = 2'b01;
      ForwardAD = (rsD != '0) && RegWriteM && (WriteRegM == rsD);
      ForwardBD = (rtD != '0) && RegWriteM && (WriteRegM == rtD);
      if (memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (issstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
      end else if (lwstall || brstall || sbstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)                         StallCnt <= '0;
    else if (StallD && (StallCnt != '1)) StallCnt <= StallCnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against a rule-level reference model, with directed pipeline scenarios.
module tb_hazard_scoreboard;

  localparam int unsigned AW = 5;
  localparam int unsigned MP = 4;
  localparam int unsigned TO = 12;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, LongDoneReg;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
  logic          LongIssueE, LongDoneValid, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ForwardAD, ForwardBD, StallF, StallD, StallE, StallM, FlushE, FlushW, SbFull, MemErr;
`ifdef HAZARD_PERF_EN
  logic [PW-1:0] StallCnt;
`endif

  hazard_scoreboard #(
    .REG_AW(AW), .MAX_PEND(MP), .MEM_TO(TO)
`ifdef HAZARD_PERF_EN
    , .PERF_W(PW)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .LongIssueE(LongIssueE), .LongDoneValid(LongDoneValid), .LongDoneReg(LongDoneReg),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .SbFull(SbFull), .MemErr(MemErr)
`ifdef HAZARD_PERF_EN
    , .StallCnt(StallCnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: set of pending regs, length of the current dmem wait, sticky error, stall tally.
  bit [31:0] m_pend;
  int        m_wait;
  bit        m_err;
  int        m_cnt;
  int        n_vec = 0;
  int        n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_e(input logic [AW-1:0] r);
    if (r == 0) return 2'b00;
    if (RegWriteM && WriteRegM == r) return 2'b10;
    if (RegWriteW && WriteRegW == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads(input logic [AW-1:0] r);
    return (r != 0) && (rsD == r || rtD == r);
  endfunction

  // Compare one cycle against the model, then advance the model across the clock edge.
  task automatic step();
    bit full, ms, iss, lw, br, sb, sF, sD, sE, sM, fE, fW, setp, clrp;
    logic [1:0] fa, fb;
    bit fad, fbd;
    #1;
    full = ($countones(m_pend) == MP);
    ms   = !MemReadyM && (MemReqM || m_wait > 0);
    iss  = LongIssueE && (full || (WriteRegE != 0 && m_pend[WriteRegE]));
    lw   = MemtoRegE && reads(rtE);
    br   = BranchD && ((RegWriteE && reads(WriteRegE)) || (MemtoRegM && reads(WriteRegM)));
    sb   = (rsD != 0 && m_pend[rsD]) || (rtD != 0 && m_pend[rtD]);
    {sF, sD, sE, sM, fE, fW} = ms ? 6'b111101 : iss ? 6'b111000 : (lw || br || sb) ? 6'b110010 : 6'b0;
    fa  = fwd_e(rsE);
    fb  = fwd_e(rtE);
    fad = (rsD != 0) && RegWriteM && WriteRegM == rsD;
    fbd = (rtD != 0) && RegWriteM && WriteRegM == rtD;
    if (reset) begin
      {sF, sD, sE, sM, fE, fW, fad, fbd} = '0;
      fa = 2'b00;
      fb = 2'b00;
    end
    check("ForwardAE", ForwardAE, fa);
    check("ForwardBE", ForwardBE, fb);
    check("ForwardAD", ForwardAD, fad);
    check("ForwardBD", ForwardBD, fbd);
    check("StallF", StallF, sF);
    check("StallD", StallD, sD);
    check("StallE", StallE, sE);
    check("StallM", StallM, sM);
    check("FlushE", FlushE, fE);
    check("FlushW", FlushW, fW);
    check("SbFull", SbFull, full);
    check("MemErr", MemErr, m_err);
`ifdef HAZARD_PERF_EN
    check("StallCnt", StallCnt, m_cnt);
`endif
    @(posedge clk);
    if (reset) begin
      m_pend = '0;
      m_wait = 0;
      m_err  = 0;
      m_cnt  = 0;
    end else begin
      setp = LongIssueE && !ms && !iss && WriteRegE != 0;
      clrp = LongDoneValid && m_pend[LongDoneReg];
      if (clrp) m_pend[LongDoneReg] = 1'b0;
      if (setp) m_pend[WriteRegE] = 1'b1;
      m_wait = ms ? m_wait + 1 : 0;
      if (m_wait >= TO + 1) m_err = 1;
      if (sD && m_cnt < (2**PW) - 1) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    {rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, LongDoneReg} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD} = '0;
    {LongIssueE, LongDoneValid, MemReqM} = '0;
    MemReadyM = 1'b1;
  endtask

  initial begin
    int hold;
    idle();
    reset = 1'b1;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Load-use: lw r2 ; add r3,r2,r4
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2; rtE = 2; rsD = 2; rtD = 4;
    #1 check("lwuse_stall", {StallF, StallD, FlushE}, 3'b111);
    step();
    idle(); RegWriteM = 1; MemtoRegM = 1; WriteRegM = 2; rsD = 2; rtD = 4;
    #1 check("lwuse_nostall", StallD, 1'b0);
    step();
    idle(); RegWriteW = 1; WriteRegW = 2; rsE = 2; rtE = 4;
    #1 check("lwuse_fwdW", ForwardAE, 2'b01);
    step();

    // Branch operand from M is forwarded; from E it stalls.
    idle(); RegWriteM = 1; WriteRegM = 5; BranchD = 1; rsD = 5;
    #1 check("br_fwdAD", {ForwardAD, StallD}, 2'b10);
    step();
    idle(); RegWriteE = 1; WriteRegE = 5; BranchD = 1; rsD = 5;
    #1 check("br_stallE", {StallD, FlushE}, 2'b11);
    step();

    // mul r8 then dependent add; clear becomes visible the cycle after LongDoneValid.
    idle(); LongIssueE = 1; WriteRegE = 8;
    step();
    idle(); rsD = 8; rtD = 9;
    #1 check("sb_stall0", StallD, 1'b1);
    step();
    LongDoneValid = 1; LongDoneReg = 8;
    #1 check("sb_stall_done", StallD, 1'b1);
    step();
    LongDoneValid = 0;
    #1 check("sb_released", StallD, 1'b0);
    step();

    // Fill the scoreboard, then one more issue is structural-stalled.
    for (int unsigned i = 0; i <= MP; i++) begin
      idle(); LongIssueE = 1; WriteRegE = AW'(10 + i);
      if (i == MP) #1 check("sb_full_iss", {SbFull, StallE, FlushE}, 3'b110);
      step();
    end
    for (int unsigned i = 0; i < MP; i++) begin
      idle(); LongDoneValid = 1; LongDoneReg = AW'(10 + i);
      step();
    end
    idle(); LongIssueE = 1; WriteRegE = 20;
    step();

    // dmem miss of three cycles freezes F..M and bubbles W.
    idle(); MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("mem_stall", {StallF, StallD, StallE, StallM, FlushW, FlushE}, 6'b111110);
      step();
    end
    MemReadyM = 1;
    #1 check("mem_resume", {StallF, StallM, FlushW}, 3'b000);
    step();

    // Timeout: ready low for MEM_TO+1 cycles sets sticky MemErr.
    idle(); MemReqM = 1; MemReadyM = 0;
    for (int unsigned i = 0; i <= TO; i++) begin
      #1 check("memerr_early", MemErr, 1'b0);
      step();
    end
    #1 check("memerr_set", MemErr, 1'b1);
    step();
    reset = 1;
    step();
    reset = 0; idle(); rsD = 20;
    #1 check("rst_mwait", {MemErr, StallF, StallM, SbFull}, 4'b0000);
    step();

    // Random traffic over a small register window so hazards actually collide.
    hold = 0;
    for (int n = 0; n < 1500; n++) begin
      rsD = AW'($urandom_range(0, 7)); rtD = AW'($urandom_range(0, 7));
      rsE = AW'($urandom_range(0, 7)); rtE = AW'($urandom_range(0, 7));
      WriteRegE = AW'($urandom_range(0, 7)); WriteRegM = AW'($urandom_range(0, 7));
      WriteRegW = AW'($urandom_range(0, 7)); LongDoneReg = AW'($urandom_range(0, 7));
      RegWriteE = $urandom_range(0, 1) == 0; RegWriteM = $urandom_range(0, 1) == 0;
      RegWriteW = $urandom_range(0, 1) == 0; MemtoRegE = $urandom_range(0, 3) == 0;
      MemtoRegM = $urandom_range(0, 3) == 0; BranchD = $urandom_range(0, 3) == 0;
      LongIssueE = $urandom_range(0, 2) == 0; LongDoneValid = $urandom_range(0, 3) == 0;
      MemReqM = $urandom_range(0, 3) == 0;
      if (hold == 0 && $urandom_range(0, 199) == 0) hold = TO + 3;
      MemReadyM = (hold > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (hold > 0) hold--;
      reset = $urandom_range(0, 99) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
